// File: rtl/quad_encoder_ctrl_pkg.sv
// Shared command codes and phase-state encodings for the quadrature encoder sequencer.
package quad_encoder_ctrl_pkg;

    localparam logic [1:0] OPC_HOLD = 2'd0;
    localparam logic [1:0] OPC_INC  = 2'd1;
    localparam logic [1:0] OPC_DEC  = 2'd2;
    localparam logic [1:0] OPC_CLR  = 2'd3;

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_P00  = 3'd1,
        ST_P01  = 3'd2,
        ST_P11  = 3'd3,
        ST_P10  = 3'd4
    } phase_e;

    function automatic phase_e code_to_state(input logic [1:0] code);
        unique case (code)
            2'b00:   return ST_P00;
            2'b01:   return ST_P01;
            2'b11:   return ST_P11;
            default: return ST_P10;
        endcase
    endfunction

    // Position along the forward Gray cycle, so a step is a +1/-1 difference mod 4.
    function automatic logic [1:0] gray_pos(input phase_e st);
        unique case (st)
            ST_P01:  return 2'd1;
            ST_P11:  return 2'd2;
            ST_P10:  return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/quad_encoder_ctrl_enc_input_filter.sv
// Two-flop synchroniser followed by a stability counter; the output follows the
// synchronised input only after FILT_LEN consecutive differing samples.
module quad_encoder_ctrl_enc_input_filter #(
    parameter int unsigned FILT_LEN = 3
) (
    input  logic CLK,
    input  logic RESET,
    input  logic din,
    output logic dout
);

    localparam logic [3:0] CNT_MAX = 4'(FILT_LEN - 1);

    logic [1:0] sync_q;
    logic [3:0] cnt_q, cnt_d;
    logic       filt_q, filt_d;

    always_comb begin
        filt_d = filt_q;
        cnt_d  = 4'd0;
        if (sync_q[1] != filt_q) begin
            if (cnt_q == CNT_MAX) begin
                filt_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync_q <= 2'b00;
            cnt_q  <= 4'd0;
            filt_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], din};
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign dout = filt_q;

endmodule

// File: rtl/quad_encoder_ctrl.sv
// Quadrature-encoder sequencer: filters A/B/index, decodes Gray steps and arbitrates
// host clear, index clear and steps onto the single counter command port.
module quad_encoder_ctrl
    import quad_encoder_ctrl_pkg::*;
#(
    parameter int unsigned FILT_LEN     = 3,
    parameter bit          INDEX_CLR_EN = 1'b1,
    parameter bit          SAT_ZERO     = 1'b0
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       EN,
    input  logic       ENC_A,
    input  logic       ENC_B,
    input  logic       ENC_I,
    input  logic       CLR_REQ,
    input  logic       ERR_CLR,
    input  logic       Z,
    output logic [1:0] OPC,
    output logic       DIR,
    output logic       STEP,
    output logic       ERR
);

    logic   a_f, b_f, i_f;
    phase_e state_q, state_d, new_st;
    logic [1:0] opc_q, opc_d, delta;
    logic   dir_q, dir_d, err_q, err_d, idx_q;
    logic   step_inc, step_dec, illegal, idx_rise;

    quad_encoder_ctrl_enc_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
        .CLK(CLK), .RESET(RESET), .din(ENC_A), .dout(a_f)
    );
    quad_encoder_ctrl_enc_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
        .CLK(CLK), .RESET(RESET), .din(ENC_B), .dout(b_f)
    );
    quad_encoder_ctrl_enc_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_i (
        .CLK(CLK), .RESET(RESET), .din(ENC_I), .dout(i_f)
    );

    assign new_st   = code_to_state({a_f, b_f});
    assign delta    = gray_pos(new_st) - gray_pos(state_q);
    assign idx_rise = i_f & ~idx_q;

    // Phase decode; INIT only adopts the current code so release never yields a step.
    always_comb begin
        state_d  = new_st;
        step_inc = 1'b0;
        step_dec = 1'b0;
        illegal  = 1'b0;
        if (state_q != ST_INIT) begin
            unique case (delta)
                2'd1:    step_inc = 1'b1;
                2'd3:    step_dec = 1'b1;
                2'd2:    illegal  = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        opc_d = OPC_HOLD;
        if (CLR_REQ) begin
            opc_d = OPC_CLR;
        end else if (INDEX_CLR_EN && idx_rise) begin
            opc_d = OPC_CLR;
        end else if (EN && step_inc) begin
            opc_d = OPC_INC;
        end else if (EN && step_dec && !(SAT_ZERO && Z)) begin
            opc_d = OPC_DEC;
        end

        dir_d = dir_q;
        if (step_inc) dir_d = 1'b1;
        if (step_dec) dir_d = 1'b0;

        err_d = err_q;
        if (ERR_CLR || CLR_REQ) err_d = 1'b0;
        if (illegal) err_d = 1'b1;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_INIT;
            opc_q   <= OPC_HOLD;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
            idx_q   <= i_f;
        end
    end

    assign OPC  = opc_q;
    assign DIR  = dir_q;
    assign ERR  = err_q;
    assign STEP = (opc_q == OPC_INC) || (opc_q == OPC_DEC);

endmodule
